// File: rtl/axi_regslice.sv
// AXI4 register slice: five independent per-channel slices (bypass / full skid / forward)
// between a slave port (axis_*) and a mirrored master port (axim_*).

module axi_regslice_chan #(
  parameter int unsigned MODE  = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (MODE == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_data  = in_data;

  end else if (MODE == 2) begin : g_fwd
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Ready only looks one stage ahead: free slot or the slot drains this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (in_valid && in_ready) begin
        valid_q <= 1'b1;
        data_q  <= in_data;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end

  end else begin : g_full
    typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ready_q, valid_q;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic             push, pop;

    assign push      = in_valid && ready_q;
    assign pop       = valid_q && out_ready;
    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = main_q;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (push && !pop) begin
            state_d = S_FULL;
            skid_d  = in_data;
          end else if (pop && !push) begin
            state_d = S_EMPTY;
          end else if (push && pop) begin
            main_d  = in_data;
          end
        end
        S_FULL: begin
          // Skid beat moves forward; no push possible since ready is low here.
          if (pop) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    // Handshake flags are registered copies derived from the next state.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_EMPTY;
        ready_q <= 1'b0;
        valid_q <= 1'b0;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        state_q <= state_d;
        ready_q <= (state_d != S_FULL);
        valid_q <= (state_d != S_EMPTY);
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end
  end

endmodule

module axi_regslice #(
  parameter int unsigned P_AXI_IDWIDTH = 5,
  parameter int unsigned P_ADDRWIDTH   = 32,
  parameter int unsigned P_DATAWIDTH   = 64,
  parameter int unsigned P_USERWIDTH   = 1,
  parameter int unsigned P_AW_MODE     = 1,
  parameter int unsigned P_W_MODE      = 1,
  parameter int unsigned P_B_MODE      = 1,
  parameter int unsigned P_AR_MODE     = 1,
  parameter int unsigned P_R_MODE      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  // slave AW
  input  logic [P_ADDRWIDTH-1:0]     axis_awaddr,
  input  logic [7:0]                 axis_awlen,
  input  logic [2:0]                 axis_awsize,
  input  logic [1:0]                 axis_awburst,
  input  logic [P_AXI_IDWIDTH-1:0]   axis_awid,
  input  logic                       axis_awlock,
  input  logic [3:0]                 axis_awcache,
  input  logic [2:0]                 axis_awprot,
  input  logic [P_USERWIDTH-1:0]     axis_awuser,
  input  logic                       axis_awvalid,
  output logic                       axis_awready,
  // slave W
  input  logic [P_AXI_IDWIDTH-1:0]   axis_wid,
  input  logic [P_DATAWIDTH-1:0]     axis_wdata,
  input  logic [P_DATAWIDTH/8-1:0]   axis_wstrb,
  input  logic                       axis_wlast,
  input  logic [P_USERWIDTH-1:0]     axis_wuser,
  input  logic                       axis_wvalid,
  output logic                       axis_wready,
  // slave B
  output logic [P_AXI_IDWIDTH-1:0]   axis_bid,
  output logic [1:0]                 axis_bresp,
  output logic [P_USERWIDTH-1:0]     axis_buser,
  output logic                       axis_bvalid,
  input  logic                       axis_bready,
  // slave AR
  input  logic [P_ADDRWIDTH-1:0]     axis_araddr,
  input  logic [7:0]                 axis_arlen,
  input  logic [2:0]                 axis_arsize,
  input  logic [1:0]                 axis_arburst,
  input  logic [P_AXI_IDWIDTH-1:0]   axis_arid,
  input  logic                       axis_arlock,
  input  logic [3:0]                 axis_arcache,
  input  logic [2:0]                 axis_arprot,
  input  logic [P_USERWIDTH-1:0]     axis_aruser,
  input  logic                       axis_arvalid,
  output logic                       axis_arready,
  // slave R
  output logic [P_AXI_IDWIDTH-1:0]   axis_rid,
  output logic [P_DATAWIDTH-1:0]     axis_rdata,
  output logic [1:0]                 axis_rresp,
  output logic                       axis_rlast,
  output logic [P_USERWIDTH-1:0]     axis_ruser,
  output logic                       axis_rvalid,
  input  logic                       axis_rready,
  // master AW
  output logic [P_ADDRWIDTH-1:0]     axim_awaddr,
  output logic [7:0]                 axim_awlen,
  output logic [2:0]                 axim_awsize,
  output logic [1:0]                 axim_awburst,
  output logic [P_AXI_IDWIDTH-1:0]   axim_awid,
  output logic                       axim_awlock,
  output logic [3:0]                 axim_awcache,
  output logic [2:0]                 axim_awprot,
  output logic [P_USERWIDTH-1:0]     axim_awuser,
  output logic                       axim_awvalid,
  input  logic                       axim_awready,
  // master W
  output logic [P_AXI_IDWIDTH-1:0]   axim_wid,
  output logic [P_DATAWIDTH-1:0]     axim_wdata,
  output logic [P_DATAWIDTH/8-1:0]   axim_wstrb,
  output logic                       axim_wlast,
  output logic [P_USERWIDTH-1:0]     axim_wuser,
  output logic                       axim_wvalid,
  input  logic                       axim_wready,
  // master B
  input  logic [P_AXI_IDWIDTH-1:0]   axim_bid,
  input  logic [1:0]                 axim_bresp,
  input  logic [P_USERWIDTH-1:0]     axim_buser,
  input  logic                       axim_bvalid,
  output logic                       axim_bready,
  // master AR
  output logic [P_ADDRWIDTH-1:0]     axim_araddr,
  output logic [7:0]                 axim_arlen,
  output logic [2:0]                 axim_arsize,
  output logic [1:0]                 axim_arburst,
  output logic [P_AXI_IDWIDTH-1:0]   axim_arid,
  output logic                       axim_arlock,
  output logic [3:0]                 axim_arcache,
  output logic [2:0]                 axim_arprot,
  output logic [P_USERWIDTH-1:0]     axim_aruser,
  output logic                       axim_arvalid,
  input  logic                       axim_arready,
  // master R
  input  logic [P_AXI_IDWIDTH-1:0]   axim_rid,
  input  logic [P_DATAWIDTH-1:0]     axim_rdata,
  input  logic [1:0]                 axim_rresp,
  input  logic                       axim_rlast,
  input  logic [P_USERWIDTH-1:0]     axim_ruser,
  input  logic                       axim_rvalid,
  output logic                       axim_rready
);

  localparam int unsigned STRB_W = P_DATAWIDTH / 8;
  localparam int unsigned A_PW   = P_ADDRWIDTH + 8 + 3 + 2 + P_AXI_IDWIDTH + 1 + 4 + 3 + P_USERWIDTH;
  localparam int unsigned W_PW   = P_AXI_IDWIDTH + P_DATAWIDTH + STRB_W + 1 + P_USERWIDTH;
  localparam int unsigned B_PW   = P_AXI_IDWIDTH + 2 + P_USERWIDTH;
  localparam int unsigned R_PW   = P_AXI_IDWIDTH + P_DATAWIDTH + 2 + 1 + P_USERWIDTH;

  logic [A_PW-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_PW-1:0] w_in, w_out;
  logic [B_PW-1:0] b_in, b_out;
  logic [R_PW-1:0] r_in, r_out;

  // Payload packing: every non-handshake field of a channel travels as one vector.
  assign aw_in = {axis_awaddr, axis_awlen, axis_awsize, axis_awburst, axis_awid,
                  axis_awlock, axis_awcache, axis_awprot, axis_awuser};
  assign {axim_awaddr, axim_awlen, axim_awsize, axim_awburst, axim_awid,
          axim_awlock, axim_awcache, axim_awprot, axim_awuser} = aw_out;

  assign w_in = {axis_wid, axis_wdata, axis_wstrb, axis_wlast, axis_wuser};
  assign {axim_wid, axim_wdata, axim_wstrb, axim_wlast, axim_wuser} = w_out;

  assign b_in = {axim_bid, axim_bresp, axim_buser};
  assign {axis_bid, axis_bresp, axis_buser} = b_out;

  assign ar_in = {axis_araddr, axis_arlen, axis_arsize, axis_arburst, axis_arid,
                  axis_arlock, axis_arcache, axis_arprot, axis_aruser};
  assign {axim_araddr, axim_arlen, axim_arsize, axim_arburst, axim_arid,
          axim_arlock, axim_arcache, axim_arprot, axim_aruser} = ar_out;

  assign r_in = {axim_rid, axim_rdata, axim_rresp, axim_rlast, axim_ruser};
  assign {axis_rid, axis_rdata, axis_rresp, axis_rlast, axis_ruser} = r_out;

  axi_regslice_chan #(.MODE(P_AW_MODE), .WIDTH(A_PW)) u_aw (
    .clk(clk), .rst(rst),
    .in_valid(axis_awvalid), .in_ready(axis_awready), .in_data(aw_in),
    .out_valid(axim_awvalid), .out_ready(axim_awready), .out_data(aw_out)
  );

  axi_regslice_chan #(.MODE(P_W_MODE), .WIDTH(W_PW)) u_w (
    .clk(clk), .rst(rst),
    .in_valid(axis_wvalid), .in_ready(axis_wready), .in_data(w_in),
    .out_valid(axim_wvalid), .out_ready(axim_wready), .out_data(w_out)
  );

  axi_regslice_chan #(.MODE(P_B_MODE), .WIDTH(B_PW)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(axim_bvalid), .in_ready(axim_bready), .in_data(b_in),
    .out_valid(axis_bvalid), .out_ready(axis_bready), .out_data(b_out)
  );

  axi_regslice_chan #(.MODE(P_AR_MODE), .WIDTH(A_PW)) u_ar (
    .clk(clk), .rst(rst),
    .in_valid(axis_arvalid), .in_ready(axis_arready), .in_data(ar_in),
    .out_valid(axim_arvalid), .out_ready(axim_arready), .out_data(ar_out)
  );

  axi_regslice_chan #(.MODE(P_R_MODE), .WIDTH(R_PW)) u_r (
    .clk(clk), .rst(rst),
    .in_valid(axim_rvalid), .in_ready(axim_rready), .in_data(r_in),
    .out_valid(axis_rvalid), .out_ready(axis_rready), .out_data(r_out)
  );

endmodule

// File: tb/tb_axi_regslice.sv
// Bench for axi_regslice: random traffic on all five channels checked against
// per-channel reference queues (AW/W/R full skid, AR forward, B bypass).

module tb_axi_regslice;

  localparam int MODE_AW = 1;
  localparam int MODE_W  = 1;
  localparam int MODE_B  = 0;
  localparam int MODE_AR = 2;
  localparam int MODE_R  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] axis_awaddr, axim_awaddr, axis_araddr, axim_araddr;
  logic [7:0]  axis_awlen, axim_awlen, axis_arlen, axim_arlen;
  logic [2:0]  axis_awsize, axim_awsize, axis_arsize, axim_arsize;
  logic [1:0]  axis_awburst, axim_awburst, axis_arburst, axim_arburst;
  logic [4:0]  axis_awid, axim_awid, axis_arid, axim_arid;
  logic        axis_awlock, axim_awlock, axis_arlock, axim_arlock;
  logic [3:0]  axis_awcache, axim_awcache, axis_arcache, axim_arcache;
  logic [2:0]  axis_awprot, axim_awprot, axis_arprot, axim_arprot;
  logic [0:0]  axis_awuser, axim_awuser, axis_aruser, axim_aruser;
  logic        axis_awvalid, axis_awready, axim_awvalid, axim_awready;
  logic        axis_arvalid, axis_arready, axim_arvalid, axim_arready;
  logic [4:0]  axis_wid, axim_wid;
  logic [63:0] axis_wdata, axim_wdata;
  logic [7:0]  axis_wstrb, axim_wstrb;
  logic        axis_wlast, axim_wlast;
  logic [0:0]  axis_wuser, axim_wuser;
  logic        axis_wvalid, axis_wready, axim_wvalid, axim_wready;
  logic [4:0]  axis_bid, axim_bid;
  logic [1:0]  axis_bresp, axim_bresp;
  logic [0:0]  axis_buser, axim_buser;
  logic        axis_bvalid, axis_bready, axim_bvalid, axim_bready;
  logic [4:0]  axis_rid, axim_rid;
  logic [63:0] axis_rdata, axim_rdata;
  logic [1:0]  axis_rresp, axim_rresp;
  logic        axis_rlast, axim_rlast;
  logic [0:0]  axis_ruser, axim_ruser;
  logic        axis_rvalid, axis_rready, axim_rvalid, axim_rready;

  axi_regslice #(
    .P_AXI_IDWIDTH(5), .P_ADDRWIDTH(32), .P_DATAWIDTH(64), .P_USERWIDTH(1),
    .P_AW_MODE(MODE_AW), .P_W_MODE(MODE_W), .P_B_MODE(MODE_B),
    .P_AR_MODE(MODE_AR), .P_R_MODE(MODE_R)
  ) dut (
    .clk(clk), .rst(rst),
    .axis_awaddr(axis_awaddr), .axis_awlen(axis_awlen), .axis_awsize(axis_awsize),
    .axis_awburst(axis_awburst), .axis_awid(axis_awid), .axis_awlock(axis_awlock),
    .axis_awcache(axis_awcache), .axis_awprot(axis_awprot), .axis_awuser(axis_awuser),
    .axis_awvalid(axis_awvalid), .axis_awready(axis_awready),
    .axis_wid(axis_wid), .axis_wdata(axis_wdata), .axis_wstrb(axis_wstrb),
    .axis_wlast(axis_wlast), .axis_wuser(axis_wuser),
    .axis_wvalid(axis_wvalid), .axis_wready(axis_wready),
    .axis_bid(axis_bid), .axis_bresp(axis_bresp), .axis_buser(axis_buser),
    .axis_bvalid(axis_bvalid), .axis_bready(axis_bready),
    .axis_araddr(axis_araddr), .axis_arlen(axis_arlen), .axis_arsize(axis_arsize),
    .axis_arburst(axis_arburst), .axis_arid(axis_arid), .axis_arlock(axis_arlock),
    .axis_arcache(axis_arcache), .axis_arprot(axis_arprot), .axis_aruser(axis_aruser),
    .axis_arvalid(axis_arvalid), .axis_arready(axis_arready),
    .axis_rid(axis_rid), .axis_rdata(axis_rdata), .axis_rresp(axis_rresp),
    .axis_rlast(axis_rlast), .axis_ruser(axis_ruser),
    .axis_rvalid(axis_rvalid), .axis_rready(axis_rready),
    .axim_awaddr(axim_awaddr), .axim_awlen(axim_awlen), .axim_awsize(axim_awsize),
    .axim_awburst(axim_awburst), .axim_awid(axim_awid), .axim_awlock(axim_awlock),
    .axim_awcache(axim_awcache), .axim_awprot(axim_awprot), .axim_awuser(axim_awuser),
    .axim_awvalid(axim_awvalid), .axim_awready(axim_awready),
    .axim_wid(axim_wid), .axim_wdata(axim_wdata), .axim_wstrb(axim_wstrb),
    .axim_wlast(axim_wlast), .axim_wuser(axim_wuser),
    .axim_wvalid(axim_wvalid), .axim_wready(axim_wready),
    .axim_bid(axim_bid), .axim_bresp(axim_bresp), .axim_buser(axim_buser),
    .axim_bvalid(axim_bvalid), .axim_bready(axim_bready),
    .axim_araddr(axim_araddr), .axim_arlen(axim_arlen), .axim_arsize(axim_arsize),
    .axim_arburst(axim_arburst), .axim_arid(axim_arid), .axim_arlock(axim_arlock),
    .axim_arcache(axim_arcache), .axim_arprot(axim_arprot), .axim_aruser(axim_aruser),
    .axim_arvalid(axim_arvalid), .axim_arready(axim_arready),
    .axim_rid(axim_rid), .axim_rdata(axim_rdata), .axim_rresp(axim_rresp),
    .axim_rlast(axim_rlast), .axim_ruser(axim_ruser),
    .axim_rvalid(axim_rvalid), .axim_rready(axim_rready)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: per-channel queue of accepted-but-undelivered beats.
  logic [127:0] mq[5][$];
  bit post_rst = 1'b1;
  int w_seq = 0;
  bit t1_mode = 1'b0;
  bit t2_mode = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chan(input int c, input string name, input int mode,
                      input logic iv, input logic ir, input logic [127:0] ip,
                      input logic ov, input logic ordy, input logic [127:0] op);
    bit exp_ov, exp_ir;
    if (mode == 0) begin
      check({name, "_valid"}, 128'(ov), 128'(iv));
      check({name, "_ready"}, 128'(ir), 128'(ordy));
      check({name, "_data"}, op, ip);
    end else begin
      exp_ov = (mq[c].size() > 0);
      if (mode == 1) exp_ir = !post_rst && (mq[c].size() < 2);
      else           exp_ir = (mq[c].size() == 0) || ordy;
      check({name, "_valid"}, 128'(ov), 128'(exp_ov));
      check({name, "_ready"}, 128'(ir), 128'(exp_ir));
      if (exp_ov) check({name, "_data"}, op, mq[c][0]);
      if (rst) begin
        mq[c].delete();
      end else begin
        if (exp_ov && ordy) void'(mq[c].pop_front());
        if (iv && exp_ir) begin
          mq[c].push_back(ip);
          if (c == 1) w_seq++;
        end
      end
    end
  endtask

  task automatic eval();
    chan(0, "aw", MODE_AW, axis_awvalid, axis_awready,
         128'({axis_awaddr, axis_awlen, axis_awsize, axis_awburst, axis_awid,
               axis_awlock, axis_awcache, axis_awprot, axis_awuser}),
         axim_awvalid, axim_awready,
         128'({axim_awaddr, axim_awlen, axim_awsize, axim_awburst, axim_awid,
               axim_awlock, axim_awcache, axim_awprot, axim_awuser}));
    chan(1, "w", MODE_W, axis_wvalid, axis_wready,
         128'({axis_wid, axis_wdata, axis_wstrb, axis_wlast, axis_wuser}),
         axim_wvalid, axim_wready,
         128'({axim_wid, axim_wdata, axim_wstrb, axim_wlast, axim_wuser}));
    chan(2, "b", MODE_B, axim_bvalid, axim_bready,
         128'({axim_bid, axim_bresp, axim_buser}),
         axis_bvalid, axis_bready,
         128'({axis_bid, axis_bresp, axis_buser}));
    chan(3, "ar", MODE_AR, axis_arvalid, axis_arready,
         128'({axis_araddr, axis_arlen, axis_arsize, axis_arburst, axis_arid,
               axis_arlock, axis_arcache, axis_arprot, axis_aruser}),
         axim_arvalid, axim_arready,
         128'({axim_araddr, axim_arlen, axim_arsize, axim_arburst, axim_arid,
               axim_arlock, axim_arcache, axim_arprot, axim_aruser}));
    chan(4, "r", MODE_R, axim_rvalid, axim_rready,
         128'({axim_rid, axim_rdata, axim_rresp, axim_rlast, axim_ruser}),
         axis_rvalid, axis_rready,
         128'({axis_rid, axis_rdata, axis_rresp, axis_rlast, axis_ruser}));
    post_rst = rst;
  endtask

  function automatic logic pick(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic drive(input int pv, input int pr, input bit stall);
    axis_awaddr = $urandom; axis_awlen = 8'($urandom); axis_awsize = 3'($urandom);
    axis_awburst = 2'($urandom); axis_awid = 5'($urandom); axis_awlock = 1'($urandom);
    axis_awcache = 4'($urandom); axis_awprot = 3'($urandom); axis_awuser = 1'($urandom);
    axis_araddr = $urandom; axis_arlen = 8'($urandom); axis_arsize = 3'($urandom);
    axis_arburst = 2'($urandom); axis_arid = 5'($urandom); axis_arlock = 1'($urandom);
    axis_arcache = 4'($urandom); axis_arprot = 3'($urandom); axis_aruser = 1'($urandom);
    axis_wid = 5'($urandom); axis_wdata = {$urandom, $urandom}; axis_wstrb = 8'($urandom);
    axis_wlast = 1'($urandom); axis_wuser = 1'($urandom);
    axim_bid = 5'($urandom); axim_bresp = 2'($urandom); axim_buser = 1'($urandom);
    axim_rid = 5'($urandom); axim_rdata = {$urandom, $urandom}; axim_rresp = 2'($urandom);
    axim_rlast = 1'($urandom); axim_ruser = 1'($urandom);
    axis_awvalid = pick(pv); axis_wvalid = pick(pv); axim_bvalid = pick(pv);
    axis_arvalid = pick(pv); axim_rvalid = pick(pv);
    axim_awready = !stall && pick(pr); axim_wready = !stall && pick(pr);
    axis_bready = !stall && pick(pr); axim_arready = !stall && pick(pr);
    axis_rready = !stall && pick(pr);
    if (t1_mode) begin
      axis_awvalid = 1'b1; axis_awaddr = 32'h1000_0040; axis_awlen = 8'd3;
    end
    if (t2_mode) begin
      axis_wvalid = (w_seq < 16);
      axis_wdata  = 64'(w_seq);
      axis_wlast  = (w_seq == 15);
    end
  endtask

  task automatic cycle(input int pv, input int pr, input bit stall, input bit rst_v);
    @(posedge clk);
    #1;
    rst = rst_v;
    drive(pv, pr, stall);
    @(negedge clk);
    eval();
  endtask

  initial begin
    drive(0, 100, 1'b0);
    repeat (3) cycle(0, 100, 1'b0, 1'b1);
    check("rst_awvalid", 128'(axim_awvalid), 128'(0));
    check("rst_awready", 128'(axis_awready), 128'(0));
    check("rst_rvalid", 128'(axis_rvalid), 128'(0));
    check("rst_awaddr", 128'(axim_awaddr), 128'(0));

    // Single AW beat appears on the master side one cycle later.
    cycle(0, 100, 1'b0, 1'b0);
    t1_mode = 1'b1;
    cycle(0, 100, 1'b0, 1'b0);
    t1_mode = 1'b0;
    cycle(0, 100, 1'b0, 1'b0);
    check("t1_awvalid", 128'(axim_awvalid), 128'(1));
    check("t1_awaddr", 128'(axim_awaddr), 128'(32'h1000_0040));
    check("t1_awlen", 128'(axim_awlen), 128'(3));
    repeat (5) cycle(0, 100, 1'b0, 1'b0);

    // 16 numbered W beats into a stalled sink, then released.
    w_seq = 0;
    t2_mode = 1'b1;
    repeat (20) cycle(100, 0, 1'b1, 1'b0);
    check("t2_wready_stall", 128'(axis_wready), 128'(0));
    check("t2_wvalid_stall", 128'(axim_wvalid), 128'(1));
    check("t2_first_beat", 128'(axim_wdata), 128'(0));
    repeat (40) cycle(100, 100, 1'b0, 1'b0);
    t2_mode = 1'b0;
    check("t2_drained", 128'(axim_wvalid), 128'(0));

    // Reset with two AW beats buffered.
    repeat (10) cycle(100, 0, 1'b1, 1'b0);
    check("t6_awready_full", 128'(axis_awready), 128'(0));
    cycle(100, 100, 1'b0, 1'b1);
    cycle(100, 100, 1'b0, 1'b1);
    check("t6_awvalid_rst", 128'(axim_awvalid), 128'(0));
    check("t6_awready_rst", 128'(axis_awready), 128'(0));
    check("t6_awaddr_rst", 128'(axim_awaddr), 128'(0));
    cycle(50, 50, 1'b0, 1'b0);
    check("t6_awready_lag", 128'(axis_awready), 128'(0));
    cycle(50, 50, 1'b0, 1'b0);
    check("t6_awready_rel", 128'(axis_awready), 128'(1));

    repeat (1000) cycle(50, 50, 1'b0, 1'b0);
    repeat (100) cycle(100, 100, 1'b0, 1'b0);
    check("t4_arready", 128'(axis_arready), 128'(1));
    repeat (300) cycle(70, 60, 1'b0, pick(3));
    repeat (20) cycle(50, 50, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
